// File: rtl/matmul_vec_acc.sv
// matmul_vec_acc: row-at-a-time C = A x B (or C += A x B) over synchronous-read row memories
module matmul_vec_acc #(
  parameter int MUL_SIZE  = 8,
  parameter int ELEM_BITS = 8,
  parameter int ADDR_BITS = $clog2(MUL_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_mul,
  input  logic                          accumulate,
  output logic                          busy,
  output logic                          mul_done,
  output logic [ADDR_BITS-1:0]          a_addr,
  input  logic [MUL_SIZE*ELEM_BITS-1:0] a_data,
  output logic [ADDR_BITS-1:0]          b_addr,
  input  logic [MUL_SIZE*ELEM_BITS-1:0] b_data,
  output logic [ADDR_BITS-1:0]          out_rd_addr,
  input  logic [MUL_SIZE*ELEM_BITS-1:0] out_rd_data,
  output logic [ADDR_BITS-1:0]          out_addr,
  output logic [MUL_SIZE*ELEM_BITS-1:0] out_data,
  output logic                          out_we
);
  typedef enum logic [1:0] {IDLE, LOAD, COLS, WRITE} state_t;
  state_t state, state_n;
  logic [ADDR_BITS-1:0] row, col;
  logic acc, last_col, last_row;
  logic [ELEM_BITS-1:0] res [MUL_SIZE];
  logic [ELEM_BITS-1:0] dot;
  assign last_col    = col == ADDR_BITS'(MUL_SIZE - 1);
  assign last_row    = row == ADDR_BITS'(MUL_SIZE - 1);
  assign busy        = state != IDLE;
  assign out_we      = state == WRITE;
  assign mul_done    = out_we && last_row;
  assign a_addr      = row;
  assign out_rd_addr = row;
  assign out_addr    = out_we ? row : '0;
  // column address runs one ahead of col so B data lines up; wraps to 0 on the last column
  assign b_addr      = state == COLS ? col + ADDR_BITS'(1) : '0;
  // state, counters and latched mode; row and col wrap naturally since N is a power of two
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      acc   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start_mul) begin
        acc <= accumulate;
        row <= '0;
      end
      col <= state == COLS ? col + ADDR_BITS'(1) : '0;
      if (state == WRITE) row <= row + ADDR_BITS'(1);
    end
  // next state: start is only honoured in IDLE
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start_mul ? LOAD : IDLE) :
              state == LOAD ? COLS :
              state == COLS ? (last_col ? WRITE : COLS) :
              (last_row ? IDLE : LOAD);
  end
  // truncated dot product of the current A row and B column
  always_comb begin
    dot = '0;
    for (int k = 0; k < MUL_SIZE; k++)
      dot = dot + a_data[k*ELEM_BITS +: ELEM_BITS] * b_data[k*ELEM_BITS +: ELEM_BITS];
  end
  // one result element per COLS cycle
  always_ff @(posedge clk)
    if (state == COLS) res[col] <= dot;
  // write data, optionally adding the held C row; zero outside WRITE
  always_comb begin
    out_data = '0;
    for (int j = 0; j < MUL_SIZE; j++)
      out_data[j*ELEM_BITS +: ELEM_BITS] = out_we ?
        res[j] + (acc ? out_rd_data[j*ELEM_BITS +: ELEM_BITS] : '0) : '0;
  end
endmodule

// File: doc/matmul_vec_acc.md
Name: matmul_vec_acc

Overview:
- Parametrised successor to the fixed 8-bit vector matrix multiplier: computes C = A x B, or C = C + A x B in accumulate mode, for MUL_SIZE x MUL_SIZE matrices with ELEM_BITS-wide elements.
- Sits between the MMIO/DMA front-end and three row-addressed on-chip memories: A by rows, B by columns (B transposed), and C.
- Adds a C read port for accumulate mode, a busy indication and a fixed, documented schedule.

Parameters:
- MUL_SIZE, 8, matrix dimension N; power of two, at least 2.
- ELEM_BITS, 8, width of one matrix element.
- ADDR_BITS, $clog2(MUL_SIZE), row/column address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start_mul  input  1  one-cycle start request.
- accumulate  input  1  mode select, sampled only when start_mul is accepted.
- busy  output  1  high while a multiplication is in progress.
- mul_done  output  1  one-cycle pulse, coincident with the write of the last C row.
- a_addr  output  ADDR_BITS  A row address.
- a_data  input  MUL_SIZE*ELEM_BITS  A row; element j is at bits [j*ELEM_BITS +: ELEM_BITS].
- b_addr  output  ADDR_BITS  B column address.
- b_data  input  MUL_SIZE*ELEM_BITS  B column; element i is at bits [i*ELEM_BITS +: ELEM_BITS].
- out_rd_addr  output  ADDR_BITS  C read address (accumulate mode).
- out_rd_data  input  MUL_SIZE*ELEM_BITS  C row read data.
- out_addr  output  ADDR_BITS  C write address.
- out_data  output  MUL_SIZE*ELEM_BITS  C write data.
- out_we  output  1  C write enable.

Behaviour:
- Memory model: all three memories are synchronous-read; data is valid the cycle after the address is presented and is held while the address stays stable.
- Reset: state IDLE; row and column counters 0; busy, mul_done and out_we are 0; all address outputs and out_data are 0.
- FSM states: IDLE, LOAD, COLS, WRITE.
- IDLE:
  - start_mul = 1 latches accumulate, sets row = 0 and moves to LOAD.
  - busy is 1 from the next cycle.
- LOAD (1 cycle):
  - Drives a_addr = row, out_rd_addr = row, b_addr = 0.
  - Sets col = 0 and moves to COLS.
- COLS (N cycles, col = 0..N-1):
  - a_addr and out_rd_addr stay at row; b_addr = col+1 (0 in the last COLS cycle).
  - Each cycle: res[col] <= dot(a_data, b_data), registered.
  - After col = N-1, moves to WRITE.
- WRITE (1 cycle):
  - out_we = 1, out_addr = row.
  - out_data[j] = res[j] + (acc ? out_rd_data[j] : 0).
  - If row = N-1: mul_done = 1 and the FSM moves to IDLE. Otherwise row++ and the FSM moves to LOAD.
- Arithmetic:
  - dot = sum over k of a[k]*b[k], truncated to ELEM_BITS (mod 2^ELEM_BITS).
  - The accumulate add also wraps mod 2^ELEM_BITS; there is no saturation.
  - Truncation makes the result identical for signed and unsigned interpretation.
- Timing, with start_mul accepted in cycle 0:
  - Row r is written in cycle (r+1)(N+2).
  - mul_done fires in cycle N(N+2), which is 80 for N = 8.
  - busy is high in cycles 1..N(N+2) inclusive.
- start_mul while busy, including the mul_done cycle, is ignored. A new start is accepted from the first cycle with busy = 0.
- accumulate changing during busy has no effect.
- Outside WRITE, out_we = 0 and out_data = 0.
- In non-accumulate mode out_rd_data is ignored, but out_rd_addr still tracks row.
- rst during any state: next cycle the block is in IDLE with reset values.
  - No further out_we; no mul_done.
  - Rows already written remain in C.
- rst and start_mul in the same cycle: rst wins and the start is dropped.
- The C write in WRITE and the C read of the same row do not conflict. Read data is already held from LOAD, and the write completes at the end of WRITE.

Test Plan:
- Identity x B: N=8, ELEM_BITS=8, A=I, B[i][j]=i*8+j, accumulate=0 -> C=B; out_we in cycles 10,20,...,80; mul_done only in cycle 80; busy high cycles 1..80.
- Accumulate: all-ones A and B with C preloaded to 3, accumulate=1 -> every C element = 8+3 = 11. Run again -> 19.
- Wrap-around: ELEM_BITS=8, all elements 0xFF -> each dot = 8*0xFE01 mod 256 = 8. ELEM_BITS=16 build: all elements 0x0100 -> 0.
- Start while busy: pulse start_mul in cycles 5 and 80 -> exactly 8 writes and one mul_done. A pulse in cycle 81 starts a new run; its mul_done is in cycle 161.
- Reset mid-operation: rst in cycle 25 (row 2 in COLS) -> from cycle 26 busy=0 and out_we=0; rows 0-1 written, rows 2-7 untouched. A subsequent start completes normally.
- Non-square data check: random A and B, N=4, ELEM_BITS=12, accumulate=0 vs reference model -> all 4 rows match mod 2^12; mul_done in cycle 24.
